// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: pipeline WB has priority, queued divide results
// drain into idle cycles, and a busy-bit scoreboard stalls decode on RAW/WAW hazards.
module rf_wb_arbiter #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            div_valid,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_wd,
    output logic            div_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd_chk,
    output logic            hz_stall,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic [4:0]      out_cnt
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [4:0]  CNT_MAX = 5'(MAX_OUT);

    logic [4:0]      fifo_rd_q [DEPTH];
    logic [XLEN-1:0] fifo_wd_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      cnt_q, cnt_d;

    logic            fifo_empty, fifo_full;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_wd;
    logic            wb_act, pop, push, iss_acc;

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; ready never depends on valid, and an unaccepted producer holds its data.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_rd    = fifo_rd_q[rd_ptr_q[AW-1:0]];
    assign head_wd    = fifo_wd_q[rd_ptr_q[AW-1:0]];

    assign div_ready  = !fifo_full;
    assign push       = div_valid && div_ready;

    // A WB write to x0 is not a real write, so the queue may use that cycle.
    assign wb_act     = rst_n && wb_we && (wb_rd != 5'd0);
    assign pop        = rst_n && !wb_act && !fifo_empty;

    assign iss_ready  = !((iss_rd != 5'd0) && busy_q[iss_rd]) && (cnt_q < CNT_MAX);
    assign iss_acc    = iss_valid && iss_ready;

    assign hz_stall   = ((rs1 != 5'd0) && busy_q[rs1]) ||
                        ((rs2 != 5'd0) && busy_q[rs2]) ||
                        ((rd_chk != 5'd0) && busy_q[rd_chk]);
    assign out_cnt    = cnt_q;

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = '0;
        if (wb_act) begin
            rf_we = 1'b1;
            rf_a3 = wb_rd;
            rf_wd = wb_wd;
        end else if (pop) begin
            rf_we = (head_rd != 5'd0);
            rf_a3 = head_rd;
            rf_wd = head_wd;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    // Issue set is applied after pop clear so a re-issued rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (iss_acc && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (iss_acc && !pop) begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 5'd1;
            end
        end else if (!iss_acc && pop) begin
            if (cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
            cnt_q    <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q[AW-1:0]] <= div_rd;
            fifo_wd_q[wr_ptr_q[AW-1:0]] <= div_wd;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus random stimulus for rf_wb_arbiter, checked against a queue-based
// reference model of the write port, divide-result FIFO and scoreboard.
module tb_rf_wb_arbiter;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            div_valid;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_wd;
  logic            div_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_ready;
  logic [4:0]      rs1, rs2, rd_chk;
  logic            hz_stall;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      out_cnt;

  rf_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .div_valid(div_valid), .div_rd(div_rd), .div_wd(div_wd), .div_ready(div_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk), .hz_stall(hz_stall),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .out_cnt(out_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: pending results as {rd, wd}, busy set, outstanding count
  logic [XLEN+4:0] exp_q[$];
  bit   [31:0]     busy_m;
  int              cnt_m;
  int              total = 0;
  int              bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_wd = 0;
    div_valid = 0; div_rd = 0; div_wd = 0;
    iss_valid = 0; iss_rd = 0;
    rs1 = 0; rs2 = 0; rd_chk = 0;
  endtask

  // One clock: compare outputs against the model, take the edge, advance the model.
  task automatic step();
    logic            e_wb, e_pop, e_we, e_div_rdy, e_iss_rdy, e_hz;
    logic [4:0]      hrd, e_a3;
    logic [XLEN-1:0] e_wd;
    bit              iss_ok;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      busy_m = '0;
      cnt_m  = 0;
    end
    e_wb  = rst_n && wb_we && (wb_rd != 0);
    e_pop = rst_n && !e_wb && (exp_q.size() > 0);
    hrd   = e_pop ? exp_q[0][XLEN+4:XLEN] : 5'd0;
    e_we  = e_wb || (e_pop && hrd != 0);
    e_a3  = e_wb ? wb_rd : (e_pop ? hrd : 5'd0);
    e_wd  = e_wb ? wb_wd : (e_pop ? exp_q[0][XLEN-1:0] : '0);
    e_div_rdy = exp_q.size() < DEPTH;
    e_iss_rdy = !(iss_rd != 0 && busy_m[iss_rd]) && (cnt_m < MAX_OUT);
    e_hz = (rs1 != 0 && busy_m[rs1]) || (rs2 != 0 && busy_m[rs2]) ||
           (rd_chk != 0 && busy_m[rd_chk]);
    chk("rf_we",     32'(rf_we),     32'(e_we));
    chk("rf_a3",     32'(rf_a3),     32'(e_a3));
    chk("rf_wd",     rf_wd,          e_wd);
    chk("div_ready", 32'(div_ready), 32'(e_div_rdy));
    chk("iss_ready", 32'(iss_ready), 32'(e_iss_rdy));
    chk("hz_stall",  32'(hz_stall),  32'(e_hz));
    chk("out_cnt",   32'(out_cnt),   32'(cnt_m));
    @(posedge clk);
    #1;
    if (rst_n) begin
      iss_ok = iss_valid && e_iss_rdy;
      if (e_pop) begin
        void'(exp_q.pop_front());
        busy_m[hrd] = 1'b0;
      end
      if (div_valid && e_div_rdy) exp_q.push_back({div_rd, div_wd});
      if (iss_ok && iss_rd != 0) busy_m[iss_rd] = 1'b1;
      if (iss_ok && !e_pop && cnt_m < MAX_OUT) cnt_m++;
      else if (!iss_ok && e_pop && cnt_m > 0) cnt_m--;
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_rd = rd;
    step();
    iss_valid = 0; iss_rd = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    exp_q.delete(); busy_m = '0; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1;
    step();

    // reset mid-stream with two queued results
    issue(5'd20);
    issue(5'd21);
    wb_we = 1; wb_rd = 5'd3; wb_wd = 32'h1111_0000;
    div_valid = 1; div_rd = 5'd20; div_wd = 32'hA0;
    step();
    div_rd = 5'd21; div_wd = 32'hA1;
    step();
    div_valid = 0;
    rst_n = 0;
    #1;
    chk("t1_rst_we",    32'(rf_we),     32'd0);
    chk("t1_rst_cnt",   32'(out_cnt),   32'd0);
    chk("t1_rst_ready", 32'(div_ready), 32'd1);
    step();
    step();
    rst_n = 1;
    idle();
    step();
    #1;
    chk("t1_no_stale", 32'(rf_we), 32'd0);
    step();

    // idle drain
    issue(5'd5);
    step();
    step();
    div_valid = 1; div_rd = 5'd5; div_wd = 32'h0000_0007; rs1 = 5'd5;
    #1;
    chk("t2_busy5", 32'(hz_stall), 32'd1);
    step();
    div_valid = 0;
    #1;
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_a3", 32'(rf_a3), 32'd5);
    chk("t2_wd", rf_wd,      32'd7);
    step();
    #1;
    chk("t2_hz_clear", 32'(hz_stall), 32'd0);
    step();
    idle();

    // contention with the WB stage
    issue(5'd6);
    issue(5'd7);
    wb_we = 1; wb_rd = 5'd3; wb_wd = $urandom;
    div_valid = 1; div_rd = 5'd6; div_wd = 32'h66;
    step();
    div_rd = 5'd7; div_wd = 32'h77; wb_wd = $urandom;
    step();
    div_valid = 0; wb_wd = $urandom;
    #1;
    chk("t3_full", 32'(div_ready), 32'd0);
    chk("t3_wb_a3", 32'(rf_a3), 32'd3);
    step();
    wb_wd = $urandom;
    step();
    wb_we = 0;
    #1;
    chk("t3_first", 32'(rf_a3), 32'd6);
    step();
    #1;
    chk("t3_second", 32'(rf_a3), 32'd7);
    step();
    step();

    // scoreboard limits
    issue(5'd1);
    issue(5'd2);
    iss_valid = 1; iss_rd = 5'd2;
    #1;
    chk("t4_reissue", 32'(iss_ready), 32'd0);
    step();
    iss_valid = 0;
    issue(5'd3);
    issue(5'd4);
    iss_valid = 1; iss_rd = 5'd9;
    #1;
    chk("t4_limit_rdy", 32'(iss_ready), 32'd0);
    chk("t4_limit_cnt", 32'(out_cnt),   32'd4);
    step();
    iss_valid = 0;
    div_valid = 1; div_rd = 5'd1; div_wd = 32'h1;
    step();
    div_rd = 5'd2; div_wd = 32'h2;
    step();
    div_valid = 0;
    step();
    step();
    iss_valid = 1; iss_rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("t4_x0_rdy", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 0;
    #1;
    chk("t4_x0_cnt", 32'(out_cnt),  32'd3);
    chk("t4_x0_hz",  32'(hz_stall), 32'd0);
    step();
    div_valid = 1; div_rd = 5'd3; div_wd = 32'h3;
    step();
    div_rd = 5'd4; div_wd = 32'h4;
    step();
    div_rd = 5'd0; div_wd = 32'hDEAD;
    step();
    div_valid = 0;
    repeat (3) step();

    // same-cycle pop/issue of one rd, then push/pop while full
    issue(5'd10);
    div_valid = 1; div_rd = 5'd8; div_wd = 32'h88;
    step();
    div_valid = 0; iss_valid = 1; iss_rd = 5'd8;
    #1;
    chk("t5_pop8", 32'(rf_a3), 32'd8);
    step();
    iss_valid = 0; rs1 = 5'd8;
    #1;
    chk("t5_busy8", 32'(hz_stall), 32'd1);
    chk("t5_cnt",   32'(out_cnt),  32'd1);
    step();
    rs1 = 0;
    wb_we = 1; wb_rd = 5'd3; wb_wd = 32'h3333;
    div_valid = 1; div_rd = 5'd11; div_wd = 32'hB;
    step();
    div_rd = 5'd12; div_wd = 32'hC;
    step();
    wb_we = 0; div_rd = 5'd13; div_wd = 32'hD;
    #1;
    chk("t5_full_rdy", 32'(div_ready), 32'd0);
    chk("t5_head11",   32'(rf_a3),     32'd11);
    step();
    #1;
    chk("t5_head12", 32'(rf_a3), 32'd12);
    step();
    div_valid = 0;
    #1;
    chk("t5_head13", 32'(rf_a3), 32'd13);
    step();
    div_valid = 1; div_rd = 5'd8; div_wd = 32'h8;
    step();
    div_rd = 5'd10; div_wd = 32'hA;
    step();
    idle();
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      wb_rd     = 5'($urandom_range(0, 31));
      wb_we     = ($urandom_range(0, 1) == 1) && !busy_m[wb_rd];
      wb_wd     = $urandom;
      div_valid = ($urandom_range(0, 2) == 0);
      div_rd    = 5'($urandom_range(0, 31));
      div_wd    = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1       = 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      rd_chk    = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
